// File: rtl/ram_burst_writer_pkg.sv
// Shared constants and FSM state type for the burst writer and its register file.
package ram_burst_writer_pkg;

    localparam int RBW_DATA_W = 8;
    localparam int RBW_ADDR_W = 4;
    localparam int RBW_DEPTH  = 1 << RBW_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_16x8_regfile.sv
// Register array: async-reset clear, one synchronous write port, one combinational read port.
module ram_16x8_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read is unclocked: a same-address write shows up only after the edge.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ram_burst_writer.sv
// Burst writer: valid/ready byte stream into a 16x8 array at auto-incrementing addresses.
// Optional running XOR checksum enabled by defining RAM_BURST_WRITER_CHECKSUM_EN.
module ram_burst_writer
    import ram_burst_writer_pkg::*;
#(
    parameter int DATA_W = RBW_DATA_W,
    parameter int ADDR_W = RBW_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] checksum
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic              beat;
    logic              start_ok;

    assign wr_ready = (state_reg == WRITE);
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign err      = err_reg;
    assign beat     = wr_ready && wr_valid;
    assign start_ok = (state_reg == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    ptr_next   = start_addr;
                    cnt_next   = burst_len;
                    err_next   = 1'b0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (start) err_next = 1'b1;
                if (wr_valid) begin
                    // Pointer wraps naturally at the address width.
                    ptr_next = ptr_reg + 1'b1;
                    if (cnt_reg == '0) state_next = DONE;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                if (start) err_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        checksum_reg <= '0;
        else if (start_ok) checksum_reg <= '0;
        else if (beat)     checksum_reg <= checksum_reg ^ wr_data;
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

    ram_16x8_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat),
        .waddr (ptr_reg),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ram_burst_writer.sv
// Directed self-checking bench for ram_burst_writer (default or checksum build).
module tb_ram_burst_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [3:0] burst_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] checksum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_burst_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .checksum   (checksum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cs(input logic [7:0] v);
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic begin_burst(input logic [3:0] a, input logic [3:0] len);
        start = 1'b1; start_addr = a; burst_len = len;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] basic_data [4];
    logic [7:0] wrap_data  [4];
    logic [3:0] wrap_addr  [4];

    initial begin
        basic_data = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        wrap_data  = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        wrap_addr  = '{4'd14, 4'd15, 4'd0, 4'd1};

        rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_checksum", checksum, 0);
        rst_n = 1'b1;
        tick();

        // Basic burst
        begin_burst(4'd0, 4'd3);
        $display("basic: start addr=0 len=3");
        check("basic_ready", wr_ready, 1);
        check("basic_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = basic_data[i];
            check("basic_predone", done, 0);
            tick();
            $display("basic: beat %0d data=%h", i, basic_data[i]);
        end
        wr_valid = 1'b0;
        check("basic_done", done, 1);
        check("basic_done_ready", wr_ready, 0);
        check("basic_done_busy", busy, 1);
        check("basic_checksum", checksum, exp_cs(8'h04));
        tick();
        check("basic_done_drop", done, 0);
        check("basic_idle_busy", busy, 0);
        for (int i = 0; i < 4; i++) read_check("basic_rd", 4'(i), basic_data[i]);
        read_check("basic_rd4", 4'd4, 8'h00);

        // Wrap with backpressure
        begin_burst(4'd14, 4'd3);
        $display("wrap: start addr=14 len=3");
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = wrap_data[i];
            tick();
            $display("wrap: beat %0d data=%h", i, wrap_data[i]);
            if (i < 3) begin
                wr_valid = 1'b0; wr_data = 8'hFF;
                tick();
                check("wrap_stall_done", done, 0);
                check("wrap_stall_busy", busy, 1);
            end
        end
        wr_valid = 1'b0;
        check("wrap_done", done, 1);
        tick();
        for (int i = 0; i < 4; i++) read_check("wrap_rd", wrap_addr[i], wrap_data[i]);
        read_check("wrap_rd2", 4'd2, 8'hC3);
        read_check("wrap_rd13", 4'd13, 8'h00);

        // Illegal start during WRITE and DONE
        begin_burst(4'd8, 4'd1);
        $display("illegal: start addr=8 len=1");
        wr_valid = 1'b1; wr_data = 8'h88;
        start = 1'b1; start_addr = 4'd3; burst_len = 4'd7;
        tick();
        start = 1'b0;
        check("illegal_err", err, 1);
        wr_data = 8'h99;
        tick();
        wr_valid = 1'b0;
        check("illegal_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("illegal_done_start_busy", busy, 0);
        check("illegal_err_sticky", err, 1);
        read_check("illegal_rd8", 4'd8, 8'h88);
        read_check("illegal_rd9", 4'd9, 8'h99);
        read_check("illegal_rd3", 4'd3, 8'hD4);

        // Same-cycle read/write at address 5
        begin_burst(4'd5, 4'd0);
        $display("samecycle: start addr=5 len=0");
        check("samecycle_err_clear", err, 0);
        wr_valid = 1'b1; wr_data = 8'h5A;
        read_check("samecycle_before", 4'd5, 8'h00);
        tick();
        wr_valid = 1'b0;
        check("samecycle_after", rd_data, 8'h5A);
        check("samecycle_done", done, 1);
        tick();

        // Full 16-beat burst
        begin_burst(4'd0, 4'd15);
        $display("full: start addr=0 len=15");
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("full_done", done, 1);
        check("full_checksum", checksum, exp_cs(8'h00));
        tick();
        for (int i = 0; i < 16; i++) read_check("full_rd", 4'(i), 8'(8'h10 + i));

        // Reset mid-burst after 2 of 4 beats
        begin_burst(4'd0, 4'd3);
        $display("reset: start addr=0 len=3, abort after 2 beats");
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 8'hC0;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_ready", wr_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_checksum", checksum, 0);
        for (int i = 0; i < 16; i++) read_check("midrst_rd", 4'(i), 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", done, 0);
        end
        wr_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
